load_store_unit: RTL and testbench

- Data-memory stage directly downstream of the single-cycle datapath.
- Consumes the ALU address, store data (rs2) and funct3, and drives a valid/ready memory bus with byte enables.
- Returns sign- or zero-extended load data for the result mux.
- Raises stall so the core freezes pc and the register file until the access completes, replacing the current zero-latency memory assumption.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/lsu_align.sv | 82 ++++++++
 rtl/load_store_unit.sv | 155 +++++++++++++++
 tb/tb_load_store_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the load/store path: funct3 access codes, LSU state encoding, timeout default.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

    // funct3 encodings for loads (LB..LHU) and stores (SB..SW)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } lsu_state_t;

    // Bus cycles allowed across REQ + WAIT_R before an access is aborted
    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lsu_align.sv
// Combinational access decoder: legality, byte enables and lane replication for requests; lane select + extension for load returns.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
// Ports: funct3/write/off/wdata -> legal/be/wdata_rep (request side);
//        ld_funct3/ld_off/raw -> rdata_ext (response side, fed from latched request fields).
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        write,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic        legal,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] raw,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Request side. Stores only exist for the three signed-size codes, so the
    // unsigned load codes are legal only when write=0.
    always_comb begin
        legal     = 1'b0;
        be        = 4'b0000;
        wdata_rep = wdata;
        case (funct3)
            F3_LB: begin
                legal     = 1'b1;
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
            end
            F3_LH: begin
                legal     = !off[0];
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            F3_LW: begin
                legal     = (off == 2'b00);
                be        = 4'b1111;
            end
            F3_LBU: begin
                legal     = !write;
                be        = 4'b0001 << off;
            end
            F3_LHU: begin
                legal     = !write && !off[0];
                be        = off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                legal     = 1'b0;
            end
        endcase
    end

    // Response side: pick the addressed lane out of the raw word, then extend.
    always_comb begin
        byte_sel = raw[7:0];
        case (ld_off)
            2'd0: byte_sel = raw[7:0];
            2'd1: byte_sel = raw[15:8];
            2'd2: byte_sel = raw[23:16];
            2'd3: byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase
        half_sel = ld_off[1] ? raw[31:16] : raw[15:0];

        rdata_ext = raw;
        case (ld_funct3)
            F3_LB:   rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   rdata_ext = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  rdata_ext = {24'd0, byte_sel};
            F3_LHU:  rdata_ext = {16'd0, half_sel};
            default: rdata_ext = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: turns one load/store from the core into a valid/ready bus access and returns extended load data.
// Latency: store 3 cycles, load 4 cycles, illegal access 2 cycles (IDLE..DONE inclusive); timeout aborts after TIMEOUT_CYCLES.
// Backpressure: holds mem_req until mem_gnt, waits for mem_rvalid; stall freezes the core until DONE.
// Ports: clk/reset (sync, active-low); core side req_valid/req_write/funct3/addr/wdata in,
//        stall/rsp_valid/rdata/err out; bus side mem_req/mem_we/mem_addr/mem_be/mem_wdata out,
//        mem_gnt/mem_rvalid/mem_rdata in.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    // Counter holds the number of REQ/WAIT_R cycles already spent; the cycle
    // in which it equals TMO_LAST is the final one allowed.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [15:0] tmo_cnt;
    logic        tmo_hit;

    logic        legal;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] ld_ext;

    lsu_align u_align (
        .funct3    (funct3),
        .write     (req_write),
        .off       (addr[1:0]),
        .wdata     (wdata),
        .legal     (legal),
        .be        (be),
        .wdata_rep (wdata_rep),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .raw       (mem_rdata),
        .rdata_ext (ld_ext)
    );

    assign stall = req_valid && (state != DONE);

    // >= rather than == so a read granted in its last allowed REQ cycle still
    // times out if the data does not come back in the first WAIT_R cycle.
    assign tmo_hit = (tmo_cnt >= TMO_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            tmo_cnt   <= 16'd0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (legal) begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_write;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= be;
                            mem_wdata <= wdata_rep;
                            f3_q      <= funct3;
                            off_q     <= addr[1:0];
                            tmo_cnt   <= 16'd0;
                            state     <= REQ;
                        end else begin
                            err       <= 1'b1;
                            rsp_valid <= 1'b1;
                            rdata     <= 32'd0;
                            state     <= DONE;
                        end
                    end
                end
                REQ: begin
                    // A grant on the final allowed cycle wins over the timeout:
                    // the bus has already taken the request.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            rsp_valid <= 1'b1;
                            rdata     <= 32'd0;
                            state     <= DONE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                            state   <= WAIT_R;
                        end
                    end else if (tmo_hit) begin
                        mem_req   <= 1'b0;
                        err       <= 1'b1;
                        rsp_valid <= 1'b1;
                        rdata     <= 32'd0;
                        state     <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid) begin
                        rdata     <= ld_ext;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else if (tmo_hit) begin
                        err       <= 1'b1;
                        rsp_valid <= 1'b1;
                        rdata     <= 32'd0;
                        state     <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                DONE: begin
                    // Response fields are only meaningful for this one cycle.
                    rsp_valid <= 1'b0;
                    err       <= 1'b0;
                    rdata     <= 32'd0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a reactive bus responder.
// Latency: n/a.
// Backpressure: grant delay and read-return delay are set per access.
module tb_load_store_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall, rsp_valid, err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    // Second instance with a short timeout; its bus never grants.
    logic        req_valid_t = 1'b0;
    logic        stall_t, rsp_valid_t, err_t, mem_req_t, mem_we_t;
    logic [31:0] rdata_t, mem_addr_t, mem_wdata_t;
    logic [3:0]  mem_be_t;
    logic        gnt_t = 1'b0;
    logic        rvalid_t = 1'b0;

    int checks = 0;
    int errors = 0;

    // Results of the last access()
    int          r_lat, r_reqc;
    logic [31:0] r_rd, r_addr, r_wd;
    logic [3:0]  r_be;
    logic        r_err, r_we, r_stall_ok, r_stable;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
        .rsp_valid(rsp_valid), .rdata(rdata), .err(err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .reset(reset), .req_valid(req_valid_t), .req_write(req_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall_t),
        .rsp_valid(rsp_valid_t), .rdata(rdata_t), .err(err_t), .mem_req(mem_req_t),
        .mem_we(mem_we_t), .mem_addr(mem_addr_t), .mem_be(mem_be_t), .mem_wdata(mem_wdata_t),
        .mem_gnt(gnt_t), .mem_rvalid(rvalid_t), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access on the main instance. Grant arrives once mem_req has been seen
    // for gnt_wait cycles; rvalid pulses rv_wait cycles after the grant cycle.
    // r_lat counts cycles from the IDLE cycle through DONE inclusive.
    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gnt_wait, input int rv_wait,
                          input logic [31:0] rword);
        int gnt_cyc;
        r_lat = -1; r_reqc = 0; r_rd = 32'hx; r_err = 1'bx;
        r_stall_ok = 1'b1; r_stable = 1'b1;
        r_addr = 32'd0; r_wd = 32'd0; r_be = 4'd0; r_we = 1'b0;
        gnt_cyc = -1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; wdata = wd;
        mem_rdata = rword;
        for (int c = 0; c < 60; c++) begin
            mem_gnt    = mem_req && (r_reqc >= gnt_wait);
            mem_rvalid = (gnt_cyc >= 0) && (c - gnt_cyc == rv_wait);
            @(negedge clk);
            if (mem_req) begin
                if (r_reqc == 0) begin
                    r_addr = mem_addr; r_wd = mem_wdata; r_be = mem_be; r_we = mem_we;
                end else if (mem_addr !== r_addr || mem_be !== r_be ||
                             mem_wdata !== r_wd || mem_we !== r_we) begin
                    r_stable = 1'b0;
                end
                r_reqc++;
            end
            if (mem_gnt) gnt_cyc = c;
            if (rsp_valid) begin
                r_lat = c + 1; r_rd = rdata; r_err = err;
                if (stall) r_stall_ok = 1'b0;
                break;
            end
            if (!stall) r_stall_ok = 1'b0;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {28'd0, mem_req, mem_we, rsp_valid, err}, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1; reset = 1'b1;

        // sb, grant in the first REQ cycle
        access(1'b1, F3_SB, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'd0);
        chk("sb_lat", 32'(r_lat), 32'd3);
        chk("sb_addr", r_addr, 32'h0000_1000);
        chk("sb_be", {28'd0, r_be}, 32'h8);
        chk("sb_wdata", r_wd, 32'hABAB_ABAB);
        chk("sb_we", {31'd0, r_we}, 32'd1);
        chk("sb_err", {31'd0, r_err}, 32'd0);
        chk("sb_rdata", r_rd, 32'd0);
        chk("sb_stall", {31'd0, r_stall_ok}, 32'd1);

        // lb / lbu, byte lane 1 of 0x1234F600
        access(1'b0, F3_LB, 32'h0000_2001, 32'd0, 0, 1, 32'h1234_F600);
        chk("lb_lat", 32'(r_lat), 32'd4);
        chk("lb_rdata", r_rd, 32'hFFFF_FFF6);
        chk("lb_err", {31'd0, r_err}, 32'd0);
        chk("lb_we", {31'd0, r_we}, 32'd0);
        access(1'b0, F3_LBU, 32'h0000_2001, 32'd0, 0, 1, 32'h1234_F600);
        chk("lbu_lat", 32'(r_lat), 32'd4);
        chk("lbu_rdata", r_rd, 32'h0000_00F6);

        // lh / lhu, upper halfword
        access(1'b0, F3_LH, 32'h0000_2002, 32'd0, 0, 1, 32'h8765_4321);
        chk("lh_rdata", r_rd, 32'hFFFF_8765);
        chk("lh_be", {28'd0, r_be}, 32'hC);
        access(1'b0, F3_LHU, 32'h0000_2002, 32'd0, 0, 1, 32'h8765_4321);
        chk("lhu_rdata", r_rd, 32'h0000_8765);

        // sh lower lane and sw
        access(1'b1, F3_SH, 32'h0000_1000, 32'h1234_ABCD, 0, 0, 32'd0);
        chk("sh_be", {28'd0, r_be}, 32'h3);
        chk("sh_wdata", r_wd, 32'hABCD_ABCD);
        access(1'b1, F3_SW, 32'h0000_0100, 32'hCAFE_F00D, 0, 0, 32'd0);
        chk("sw_be", {28'd0, r_be}, 32'hF);
        chk("sw_wdata", r_wd, 32'hCAFE_F00D);

        // Illegal accesses: no bus request, 2-cycle response with err
        access(1'b0, F3_LH, 32'h0000_3001, 32'd0, 0, 1, 32'h5555_5555);
        chk("lh_mis_lat", 32'(r_lat), 32'd2);
        chk("lh_mis_req", 32'(r_reqc), 32'd0);
        chk("lh_mis_err", {31'd0, r_err}, 32'd1);
        chk("lh_mis_rdata", r_rd, 32'd0);
        access(1'b0, F3_LW, 32'h0000_3002, 32'd0, 0, 1, 32'h5555_5555);
        chk("lw_mis_err", {31'd0, r_err}, 32'd1);
        chk("lw_mis_req", 32'(r_reqc), 32'd0);
        access(1'b0, 3'b011, 32'h0000_3000, 32'd0, 0, 1, 32'h5555_5555);
        chk("ld011_err", {31'd0, r_err}, 32'd1);
        chk("ld011_lat", 32'(r_lat), 32'd2);
        access(1'b1, 3'b100, 32'h0000_3000, 32'd0, 0, 0, 32'd0);
        chk("st100_err", {31'd0, r_err}, 32'd1);
        chk("st100_req", 32'(r_reqc), 32'd0);

        // lw with grant held off 3 REQ cycles, rvalid 2 cycles after grant
        access(1'b0, F3_LW, 32'h0000_4000, 32'd0, 3, 2, 32'hDEAD_BEEF);
        chk("lw_slow_lat", 32'(r_lat), 32'd8);
        chk("lw_slow_reqc", 32'(r_reqc), 32'd4);
        chk("lw_slow_stable", {31'd0, r_stable}, 32'd1);
        chk("lw_slow_stall", {31'd0, r_stall_ok}, 32'd1);
        chk("lw_slow_rdata", r_rd, 32'hDEAD_BEEF);
        chk("lw_slow_err", {31'd0, r_err}, 32'd0);

        // Timeout on the short-timeout instance: 4 REQ cycles, then DONE with err
        begin
            int reqc_t, lat_t;
            logic e_t;
            reqc_t = 0; lat_t = -1; e_t = 1'b0;
            @(posedge clk); #1;
            req_valid_t = 1'b1; req_write = 1'b0; funct3 = F3_LW; addr = 32'h0000_6000;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (mem_req_t) reqc_t++;
                if (rsp_valid_t) begin
                    lat_t = c + 1; e_t = err_t;
                    break;
                end
                @(posedge clk); #1;
            end
            @(posedge clk); #1; req_valid_t = 1'b0;
            chk("tmo_reqc", 32'(reqc_t), 32'd4);
            chk("tmo_lat", 32'(lat_t), 32'd6);
            chk("tmo_err", {31'd0, e_t}, 32'd1);
            @(negedge clk);
            chk("tmo_idle", {30'd0, mem_req_t, rsp_valid_t}, 32'd0);
        end

        // Reset during WAIT_R; a later rvalid must be ignored
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; funct3 = F3_LW; addr = 32'h0000_5000;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk); #1; mem_gnt = 1'b1;
        @(negedge clk);
        chk("mid_req", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1; mem_gnt = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("mid_wait_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("mid_rst_ctl", {27'd0, mem_req, mem_we, rsp_valid, err, stall}, 32'd0);
        chk("mid_rst_bus", {mem_be, 28'd0} | mem_addr | mem_wdata, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        @(posedge clk); #1; mem_rvalid = 1'b0;
        @(negedge clk);
        chk("mid_rst_norsp", {31'd0, rsp_valid}, 32'd0);
        access(1'b0, F3_LW, 32'h0000_5004, 32'd0, 0, 1, 32'h0BAD_F00D);
        chk("post_rst_lat", 32'(r_lat), 32'd4);
        chk("post_rst_rdata", r_rd, 32'h0BAD_F00D);
        chk("post_rst_addr", r_addr, 32'h0000_5004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
